// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/opcode input channel and result/status output channel
// of alu_seq, bundled so the source, the ALU and the sink share one view.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready
// are both high. The producer holds its payload stable while valid is high
// and ready is low. It keeps valid asserted until the transfer completes.
// This applies to in_valid/in_ready (source -> ALU) and to
// out_valid/out_ready (ALU -> writeback).
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       fsl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] mul_high;
    logic [3:0]       SREG;

    // Source/sink side (decoder feeding operands, writeback taking results)
    modport master (
        output in_valid, A, B, fsl, out_ready,
        input  in_ready, out_valid, result, mul_high, SREG
    );

    // ALU side
    modport slave (
        input  in_valid, A, B, fsl, out_ready,
        output in_ready, out_valid, result, mul_high, SREG
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshake, persistent {V,S,C,Z}
// status register and an iterative shift-add multiplier.
//
// Optional feature macro: ALU_SEQ_SHIFT_AMT_EN. When it is defined, opcodes
// 8-D shift or rotate by B[$clog2(WIDTH)-1:0] instead of by a fixed 1.
//
// Non-MUL ops produce a result one cycle after they are accepted. MUL runs
// for WIDTH+1 cycles. During that time in_ready stays low.
// state_dbg exposes the FSM state: 0 IDLE, 1 MUL, 2 MDONE.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic       clk,
    input  logic       reset,
    alu_seq_if.slave   bus,
    output logic [1:0] state_dbg
);
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_ADDC = 4'h2;
    localparam logic [3:0] OP_SUBC = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_NAND = 4'h7;
    localparam logic [3:0] OP_LSL  = 4'h8;
    localparam logic [3:0] OP_LSR  = 4'h9;
    localparam logic [3:0] OP_ASL  = 4'hA;
    localparam logic [3:0] OP_ASR  = 4'hB;
    localparam logic [3:0] OP_ROL  = 4'hC;
    localparam logic [3:0] OP_ROR  = 4'hD;
    localparam logic [3:0] OP_MUL  = 4'hE;
    localparam logic [3:0] OP_CMP  = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MUL   = 2'd1,
        S_MDONE = 2'd2
    } state_t;

    state_t             state;
    logic               out_valid_r;
    logic [WIDTH-1:0]   result_r;
    logic [WIDTH-1:0]   mul_high_r;
    logic [3:0]         sreg_r;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   mcand;
    // High half accumulates partial products; low half starts as the
    // multiplier and is shifted out one bit per iteration.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     mul_sum;

    logic               in_ready_w;
    logic               carry_in;
    logic [WIDTH:0]     u_sum;
    logic [WIDTH:0]     s_sum;
    logic [WIDTH-1:0]   alu_r;
    logic               alu_v;
    logic               alu_s;
    logic               alu_c;
    logic               alu_z;

`ifdef ALU_SEQ_SHIFT_AMT_EN
    localparam int SH_W = $clog2(WIDTH);
    logic [SH_W-1:0]    shamt;
    logic [WIDTH:0]     sh_l;
    logic [WIDTH:0]     sh_r;
    logic [WIDTH-1:0]   rot;
    assign shamt = bus.B[SH_W-1:0];
`endif

    assign in_ready_w    = (state == S_IDLE) && (!out_valid_r || bus.out_ready);
    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.mul_high  = mul_high_r;
    assign bus.SREG      = sreg_r;
    assign state_dbg     = state;

    // Only ADDC/SUBC consume the stored carry (borrow for SUBC).
    assign carry_in = ((bus.fsl == OP_ADDC) || (bus.fsl == OP_SUBC)) && sreg_r[1];

    // One multiplier step: conditionally add the multiplicand into the high half.
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);

    // Single-cycle result and flags for every opcode except MUL.
    always_comb begin
        u_sum = '0;
        s_sum = '0;
        alu_r = '0;
        alu_v = 1'b0;
        alu_c = 1'b0;
`ifdef ALU_SEQ_SHIFT_AMT_EN
        sh_l  = '0;
        sh_r  = '0;
        rot   = '0;
`endif
        case (bus.fsl)
            OP_ADD, OP_ADDC: begin
                u_sum = {1'b0, bus.A} + {1'b0, bus.B} + {{WIDTH{1'b0}}, carry_in};
                s_sum = {bus.A[WIDTH-1], bus.A} + {bus.B[WIDTH-1], bus.B} + {{WIDTH{1'b0}}, carry_in};
                alu_r = u_sum[WIDTH-1:0];
                alu_c = u_sum[WIDTH];
                alu_v = s_sum[WIDTH] ^ s_sum[WIDTH-1];
            end
            OP_SUB, OP_SUBC: begin
                // Bit WIDTH of the zero-extended difference is the borrow.
                u_sum = {1'b0, bus.A} - {1'b0, bus.B} - {{WIDTH{1'b0}}, carry_in};
                s_sum = {bus.A[WIDTH-1], bus.A} - {bus.B[WIDTH-1], bus.B} - {{WIDTH{1'b0}}, carry_in};
                alu_r = u_sum[WIDTH-1:0];
                alu_c = u_sum[WIDTH];
                alu_v = s_sum[WIDTH] ^ s_sum[WIDTH-1];
            end
            OP_XOR:  alu_r = bus.A ^ bus.B;
            OP_AND:  alu_r = bus.A & bus.B;
            OP_OR:   alu_r = bus.A | bus.B;
            OP_NAND: alu_r = ~(bus.A & bus.B);
`ifdef ALU_SEQ_SHIFT_AMT_EN
            // A zero shift amount leaves the operand and the stored carry untouched.
            OP_LSL, OP_ASL: begin
                sh_l  = {1'b0, bus.A} << shamt;
                alu_r = sh_l[WIDTH-1:0];
                alu_c = (shamt == '0) ? sreg_r[1] : sh_l[WIDTH];
                if (bus.fsl == OP_ASL) begin
                    // Overflow if any of the top shamt+1 original bits differs from the sign.
                    for (int i = 1; i < WIDTH; i++) begin
                        if (i <= int'(shamt) && bus.A[WIDTH-1-i] != bus.A[WIDTH-1]) begin
                            alu_v = 1'b1;
                        end
                    end
                end
            end
            OP_LSR: begin
                sh_r  = {bus.A, 1'b0} >> shamt;
                alu_r = sh_r[WIDTH:1];
                alu_c = (shamt == '0) ? sreg_r[1] : sh_r[0];
            end
            OP_ASR: begin
                sh_r  = $signed({bus.A, 1'b0}) >>> shamt;
                alu_r = sh_r[WIDTH:1];
                alu_c = (shamt == '0) ? sreg_r[1] : sh_r[0];
            end
            OP_ROL: begin
                rot   = (bus.A << shamt) | (bus.A >> (WIDTH - int'(shamt)));
                alu_r = rot;
                alu_c = (shamt == '0) ? sreg_r[1] : rot[0];
            end
            OP_ROR: begin
                rot   = (bus.A >> shamt) | (bus.A << (WIDTH - int'(shamt)));
                alu_r = rot;
                alu_c = (shamt == '0) ? sreg_r[1] : rot[WIDTH-1];
            end
`else
            OP_LSL, OP_ASL: begin
                alu_r = {bus.A[WIDTH-2:0], 1'b0};
                alu_c = bus.A[WIDTH-1];
            end
            OP_LSR: begin
                alu_r = {1'b0, bus.A[WIDTH-1:1]};
                alu_c = bus.A[0];
            end
            OP_ASR: begin
                alu_r = {bus.A[WIDTH-1], bus.A[WIDTH-1:1]};
                alu_c = bus.A[0];
            end
            OP_ROL: begin
                alu_r = {bus.A[WIDTH-2:0], bus.A[WIDTH-1]};
                alu_c = bus.A[WIDTH-1];
            end
            OP_ROR: begin
                alu_r = {bus.A[0], bus.A[WIDTH-1:1]};
                alu_c = bus.A[0];
            end
`endif
            OP_CMP: begin
                alu_r = '0;
                alu_c = bus.A < bus.B;
            end
            default: alu_r = '0;
        endcase
        // CMP reports the comparison; everything else reports on the result.
        if (bus.fsl == OP_CMP) begin
            alu_z = bus.A == bus.B;
            alu_s = $signed(bus.A) < $signed(bus.B);
        end else begin
            alu_z = alu_r == '0;
            alu_s = alu_r[WIDTH-1];
        end
    end

    // Control FSM, output registers, status register and multiplier datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            out_valid_r <= 1'b0;
            result_r    <= '0;
            mul_high_r  <= '0;
            sreg_r      <= '0;
            cnt         <= '0;
            mcand       <= '0;
            acc         <= '0;
        end else begin
            // The consumer takes the held output; a load below overrides this.
            if (bus.out_ready) begin
                out_valid_r <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (bus.in_valid && in_ready_w) begin
                        if (bus.fsl == OP_MUL) begin
                            mcand <= bus.A;
                            acc   <= {{WIDTH{1'b0}}, bus.B};
                            cnt   <= CNT_W'(WIDTH);
                            state <= S_MUL;
                        end else begin
                            result_r    <= alu_r;
                            mul_high_r  <= '0;
                            sreg_r      <= {alu_v, alu_s, alu_c, alu_z};
                            out_valid_r <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    acc <= {mul_sum, acc[WIDTH-1:1]};
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= S_MDONE;
                    end
                end
                S_MDONE: begin
                    result_r    <= acc[WIDTH-1:0];
                    mul_high_r  <= acc[2*WIDTH-1:WIDTH];
                    sreg_r      <= {1'b0, acc[2*WIDTH-1], acc[2*WIDTH-1:WIDTH] != '0, acc == '0};
                    out_valid_r <= 1'b1;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed table of ALU operations with hand-computed results,
// plus sequences for multiply latency, output back-pressure and reset abort.
module tb_alu_seq;
    localparam int W = 8;

    logic       clk;
    logic       reset;
    logic [1:0] state_dbg;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    typedef struct {
        logic [3:0]   fsl;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic [W-1:0] hi;
        logic [3:0]   sreg;
    } vec_t;

    localparam int NVEC = 25;
    vec_t vecs[NVEC];

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // scoreboard compare
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // driver: called at a negedge; presents one op, returns at the next negedge
    task automatic drive_op(input string name, input logic [3:0] f, input logic [W-1:0] a,
                            input logic [W-1:0] b);
        bus.in_valid = 1'b1;
        bus.fsl      = f;
        bus.A        = a;
        bus.B        = b;
        #1;
        check({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // wait for out_valid with a cycle budget; reports latency and whether in_ready stayed low
    task automatic wait_out(input string name, output int lat, output logic busy_ok);
        lat = 0;
        busy_ok = 1'b1;
        while (bus.out_valid !== 1'b1 && lat < 30) begin
            if (bus.in_ready !== 1'b0) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        check({name, "_out_valid"}, 32'(bus.out_valid), 32'd1);
    endtask

    initial begin
        int   lat;
        logic busy_ok;
        logic stable_ok;
        logic quiet_ok;

        // fsl, a, b, result, mul_high, {V,S,C,Z}; carry chains from row to row
        vecs[0]  = '{4'h0, 8'hFF, 8'h01, 8'h00, 8'h00, 4'b0011};
        vecs[1]  = '{4'h2, 8'h10, 8'h20, 8'h31, 8'h00, 4'b0000};
        vecs[2]  = '{4'h0, 8'h7F, 8'h01, 8'h80, 8'h00, 4'b1100};
        vecs[3]  = '{4'h1, 8'h05, 8'h07, 8'hFE, 8'h00, 4'b0110};
        vecs[4]  = '{4'h3, 8'h10, 8'h05, 8'h0A, 8'h00, 4'b0000};
        vecs[5]  = '{4'h4, 8'hF0, 8'hFF, 8'h0F, 8'h00, 4'b0000};
        vecs[6]  = '{4'h5, 8'hF0, 8'h3C, 8'h30, 8'h00, 4'b0000};
        vecs[7]  = '{4'h6, 8'h0F, 8'h80, 8'h8F, 8'h00, 4'b0100};
        vecs[8]  = '{4'h7, 8'hFF, 8'hFF, 8'h00, 8'h00, 4'b0001};
        vecs[9]  = '{4'h8, 8'h81, 8'h01, 8'h02, 8'h00, 4'b0010};
        vecs[10] = '{4'h9, 8'h81, 8'h01, 8'h40, 8'h00, 4'b0010};
        vecs[11] = '{4'hA, 8'hC1, 8'h01, 8'h82, 8'h00, 4'b0110};
        vecs[12] = '{4'hB, 8'h81, 8'h01, 8'hC0, 8'h00, 4'b0110};
        vecs[13] = '{4'hC, 8'h81, 8'h01, 8'h03, 8'h00, 4'b0010};
        vecs[14] = '{4'hD, 8'h01, 8'h01, 8'h80, 8'h00, 4'b0110};
        vecs[15] = '{4'hF, 8'h80, 8'h01, 8'h00, 8'h00, 4'b0100};
        vecs[16] = '{4'hF, 8'h01, 8'h80, 8'h00, 8'h00, 4'b0010};
        vecs[17] = '{4'hF, 8'h42, 8'h42, 8'h00, 8'h00, 4'b0001};
        vecs[18] = '{4'h1, 8'h80, 8'h01, 8'h7F, 8'h00, 4'b1000};
        vecs[19] = '{4'h0, 8'h80, 8'h80, 8'h00, 8'h00, 4'b1011};
        vecs[20] = '{4'h2, 8'h00, 8'h00, 8'h01, 8'h00, 4'b0000};
        vecs[21] = '{4'h1, 8'h00, 8'h01, 8'hFF, 8'h00, 4'b0110};
        vecs[22] = '{4'h3, 8'h05, 8'h02, 8'h02, 8'h00, 4'b0000};
        vecs[23] = '{4'hE, 8'h00, 8'h05, 8'h00, 8'h00, 4'b0001};
        vecs[24] = '{4'hE, 8'h80, 8'h02, 8'h00, 8'h01, 4'b0010};

        bus.in_valid  = 1'b0;
        bus.fsl       = 4'h0;
        bus.A         = '0;
        bus.B         = '0;
        bus.out_ready = 1'b1;
        reset         = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // reset state
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_mul_high", 32'(bus.mul_high), 32'd0);
        check("rst_sreg", 32'(bus.SREG), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_state", 32'(state_dbg), 32'd0);

        // directed table
        for (int i = 0; i < NVEC; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            drive_op(nm, vecs[i].fsl, vecs[i].a, vecs[i].b);
            exp_q.push_back(vecs[i].r);
            wait_out(nm, lat, busy_ok);
            check({nm, "_result"}, 32'(bus.result), 32'(exp_q.pop_front()));
            check({nm, "_mul_high"}, 32'(bus.mul_high), 32'(vecs[i].hi));
            check({nm, "_sreg"}, 32'(bus.SREG), 32'(vecs[i].sreg));
        end

        // MUL 0xFF x 0xFF: busy for WIDTH+1 cycles
        drive_op("mul_ff", 4'hE, 8'hFF, 8'hFF);
        wait_out("mul_ff", lat, busy_ok);
        check("mul_ff_latency", 32'(lat), 32'd9);
        check("mul_ff_busy", 32'(busy_ok), 32'd1);
        check("mul_ff_result", 32'(bus.result), 32'h01);
        check("mul_ff_mul_high", 32'(bus.mul_high), 32'hFE);
        check("mul_ff_sreg", 32'(bus.SREG), 32'b0110);

        // back-pressure: XOR result held while out_ready=0
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive_op("xor_hold", 4'h4, 8'hAA, 8'hAA);
        check("xor_hold_out_valid", 32'(bus.out_valid), 32'd1);
        check("xor_hold_result", 32'(bus.result), 32'h00);
        check("xor_hold_sreg", 32'(bus.SREG), 32'b0001);
        bus.in_valid = 1'b1;
        bus.fsl      = 4'h0;
        bus.A        = 8'h01;
        bus.B        = 8'h02;
        stable_ok    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.result !== 8'h00 || bus.SREG !== 4'b0001 ||
                bus.in_ready !== 1'b0) stable_ok = 1'b0;
        end
        check("xor_hold_stable", 32'(stable_ok), 32'd1);
        bus.out_ready = 1'b1;
        #1;
        check("release_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("release_out_valid", 32'(bus.out_valid), 32'd1);
        check("release_result", 32'(bus.result), 32'h03);
        check("release_sreg", 32'(bus.SREG), 32'b0000);

        // reset three cycles into a multiply aborts it
        drive_op("mul_abort", 4'hE, 8'hFF, 8'hFF);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_sreg", 32'(bus.SREG), 32'd0);
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_state", 32'(state_dbg), 32'd0);
        quiet_ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) quiet_ok = 1'b0;
        end
        check("abort_no_output", 32'(quiet_ok), 32'd1);

        drive_op("mul_3x4", 4'hE, 8'h03, 8'h04);
        wait_out("mul_3x4", lat, busy_ok);
        check("mul_3x4_latency", 32'(lat), 32'd9);
        check("mul_3x4_result", 32'(bus.result), 32'h0C);
        check("mul_3x4_mul_high", 32'(bus.mul_high), 32'h00);
        check("mul_3x4_sreg", 32'(bus.SREG), 32'b0000);

        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
